// File: rtl/qarctan_arbiter.sv
// qarctan_arbiter
//   Two-requester round-robin front end for one shared quadrature-arctan
//   engine. It accepts one operand pair and issues a one-cycle start pulse.
//   It then waits for the engine's done strobe, or gives up after TIMEOUT
//   WAIT cycles. The angle goes to the owning requester's result slot.
//   Only one operation is in flight at any time.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester operand handshake (ready is combinational)
//   req_real/req_imag     packed signed operands, slice i = requester i
//   res_valid/res_ready   per-slot result handshake
//   res_data              packed angles, slice i = requester i
//   arc_start             one-cycle start pulse to the engine
//   arc_real/arc_imag     operands held stable for the whole operation
//   arc_data/arc_done     engine result and completion strobe
//   busy                  high whenever the FSM is not IDLE
//   timeout_err           sticky engine-hang flag, cleared only by reset
module qarctan_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*DATA_SIZE-1:0] req_real,
  input  logic [2*DATA_SIZE-1:0] req_imag,
  output logic [1:0]             res_valid,
  input  logic [1:0]             res_ready,
  output logic [2*DATA_SIZE-1:0] res_data,
  output logic                   arc_start,
  output logic [DATA_SIZE-1:0]   arc_real,
  output logic [DATA_SIZE-1:0]   arc_imag,
  input  logic [DATA_SIZE-1:0]   arc_data,
  input  logic                   arc_done,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic                   rr_reg, rr_next;
  logic                   owner_reg, owner_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [DATA_SIZE-1:0]   op_real_reg, op_real_next;
  logic [DATA_SIZE-1:0]   op_imag_reg, op_imag_next;
  logic                   err_reg, err_next;

  logic [1:0] eligible;
  logic       any_elig;
  logic       sel;
  logic       done_hit;

  // A requester whose previous angle is still unread is not eligible.
  // Otherwise a second result would overwrite the unread one.
  assign eligible = req_valid & ~res_valid;
  assign any_elig = |eligible;
  // If both requesters are eligible, rr breaks the tie.
  // If only one is eligible, bit 1 says whether it is requester 1.
  assign sel      = (eligible == 2'b11) ? rr_reg : eligible[1];
  assign done_hit = (state_reg == ST_WAIT) && arc_done;

  // reset gates req_ready so no grant is visible while reset is held.
  assign req_ready   = (reset && state_reg == ST_IDLE && any_elig) ? (2'b01 << sel) : 2'b00;
  assign arc_start   = (state_reg == ST_ISSUE);
  assign busy        = (state_reg != ST_IDLE);
  assign arc_real    = op_real_reg;
  assign arc_imag    = op_imag_reg;
  assign timeout_err = err_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      rr_reg      <= 1'b0;
      owner_reg   <= 1'b0;
      cnt_reg     <= '0;
      op_real_reg <= '0;
      op_imag_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      owner_reg   <= owner_next;
      cnt_reg     <= cnt_next;
      op_real_reg <= op_real_next;
      op_imag_reg <= op_imag_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    owner_next   = owner_reg;
    cnt_next     = cnt_reg;
    op_real_next = op_real_reg;
    op_imag_next = op_imag_reg;
    err_next     = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_elig) begin
          owner_next   = sel;
          op_real_next = sel ? req_real[2*DATA_SIZE-1:DATA_SIZE] : req_real[DATA_SIZE-1:0];
          op_imag_next = sel ? req_imag[2*DATA_SIZE-1:DATA_SIZE] : req_imag[DATA_SIZE-1:0];
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // If done and the timeout fall in the same cycle, done wins.
        if (arc_done) begin
          rr_next    = ~owner_reg;
          state_next = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          rr_next    = ~owner_reg;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One result slot per requester. Each slot's data is kept until a new
  // completion for that requester overwrites it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic                 valid_reg;
      logic [DATA_SIZE-1:0] data_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          if (valid_reg && res_ready[gi])
            valid_reg <= 1'b0;
          if (done_hit && owner_reg == 1'(gi)) begin
            valid_reg <= 1'b1;
            data_reg  <= arc_data;
          end
        end
      end

      assign res_valid[gi]                          = valid_reg;
      assign res_data[gi*DATA_SIZE +: DATA_SIZE]    = data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_qarctan_arbiter.sv
// tb_qarctan_arbiter
//   Random traffic on both requesters and consumers, with a bench-side
//   engine whose latency is chosen per operation. Some operations finish
//   early, some finish exactly on the timeout cycle, some are late and some
//   never finish. The bench also injects stray done pulses outside WAIT and
//   asserts reset mid-operation. A transaction-level model gives the
//   expected value of every output in every cycle. Its state is whether an
//   operation is outstanding, the cycles since the accept, the round-robin
//   pointer, the result slots and the error flag.
module tb_qarctan_arbiter;
  localparam int DS = 32;
  localparam int TO = 16;
  localparam int NCYC = 4000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2*DS-1:0] req_real = '0, req_imag = '0;
  logic [1:0]    res_valid;
  logic [1:0]    res_ready = 2'b00;
  logic [2*DS-1:0] res_data;
  logic          arc_start;
  logic [DS-1:0] arc_real, arc_imag;
  logic [DS-1:0] arc_data = '0;
  logic          arc_done = 1'b0;
  logic          busy, timeout_err;

  qarctan_arbiter #(.DATA_SIZE(DS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_real(req_real), .req_imag(req_imag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .arc_start(arc_start), .arc_real(arc_real), .arc_imag(arc_imag),
    .arc_data(arc_data), .arc_done(arc_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [2*DS-1:0] obs, input logic [2*DS-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  bit          m_out;      // an operation is outstanding
  int          m_p;        // cycles since accept (1 = start cycle, >=2 = waiting)
  bit          m_owner;
  bit          m_rr;
  bit [1:0]    m_resv;
  logic [DS-1:0] m_resd [2];
  bit          m_err;
  logic [DS-1:0] m_opr, m_opi;
  int          m_lat;      // start-to-done latency, 0 = engine never answers

  task automatic model_reset();
    m_out = 0; m_p = 0; m_owner = 0; m_rr = 0; m_resv = 2'b00;
    m_resd[0] = '0; m_resd[1] = '0; m_err = 0; m_opr = '0; m_opi = '0; m_lat = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, {62'd0, req_ready}, 64'd0);
    check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_val({tag, "_start"}, {63'd0, arc_start}, 64'd0);
    check_val({tag, "_resv"}, {62'd0, res_valid}, 64'd0);
    check_val({tag, "_resd"}, res_data, 64'd0);
    check_val({tag, "_err"}, {63'd0, timeout_err}, 64'd0);
    check_val({tag, "_areal"}, {32'd0, arc_real}, 64'd0);
  endtask

  initial begin
    bit [1:0] elig, exp_ready, nv;
    bit       g, in_wait, post_reset;
    int       n_resets, n_ops, r;

    model_reset();
    n_resets = 0; n_ops = 0; post_reset = 0; g = 0;
    req_valid = 2'b11;
    repeat (3) @(negedge clock);
    check_reset_outputs("por");

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      reset = 1'b1;
      req_valid = ($urandom_range(3) != 0) ? 2'($urandom) | 2'($urandom) : 2'b00;
      res_ready = 2'($urandom) & 2'($urandom);
      req_real  = {$urandom, $urandom};
      req_imag  = {$urandom, $urandom};
      in_wait   = m_out && (m_p >= 2);
      arc_data  = $urandom;
      if (m_out && m_lat != 0 && m_p == 1 + m_lat)
        arc_done = 1'b1;
      else if (!in_wait && (post_reset || $urandom_range(7) == 0))
        arc_done = 1'b1;
      else
        arc_done = 1'b0;
      post_reset = 0;
      #1;

      elig = req_valid & ~m_resv;
      exp_ready = 2'b00;
      if (!m_out && elig != 2'b00) begin
        g = (elig == 2'b11) ? m_rr : elig[1];
        exp_ready = g ? 2'b10 : 2'b01;
      end
      check_val("ready", {62'd0, req_ready}, {62'd0, exp_ready});
      check_val("busy", {63'd0, busy}, {63'd0, m_out});
      check_val("start", {63'd0, arc_start}, {63'd0, (m_out && m_p == 1)});
      check_val("resv", {62'd0, res_valid}, {62'd0, m_resv});
      check_val("resd", res_data, {m_resd[1], m_resd[0]});
      check_val("err", {63'd0, timeout_err}, {63'd0, m_err});
      if (m_out) begin
        check_val("areal", {32'd0, arc_real}, {32'd0, m_opr});
        check_val("aimag", {32'd0, arc_imag}, {32'd0, m_opi});
      end

      // Occasionally abort an operation mid-WAIT with an asynchronous reset.
      if (in_wait && n_resets < 6 && $urandom_range(30) == 0) begin
        n_resets++;
        #1 reset = 1'b0;
        req_valid = 2'b11;
        #1;
        check_reset_outputs("rst_async");
        $display("reset asserted during WAIT at %0t", $time);
        model_reset();
        @(posedge clock);
        #1;
        check_reset_outputs("rst_held");
        post_reset = 1;
        continue;
      end

      // Advance the model across the coming rising edge.
      nv = m_resv & ~res_ready;
      if (!m_out) begin
        if (exp_ready != 2'b00) begin
          m_out = 1; m_p = 1; m_owner = g;
          m_opr = g ? req_real[2*DS-1:DS] : req_real[DS-1:0];
          m_opi = g ? req_imag[2*DS-1:DS] : req_imag[DS-1:0];
          r = $urandom_range(9);
          if (r == 0)      m_lat = 0;
          else if (r == 1) m_lat = TO;
          else if (r == 2) m_lat = TO + 1;
          else             m_lat = $urandom_range(12, 1);
          n_ops++;
          $display("op %0d accept req%0d real=%0h imag=%0h lat=%0d", n_ops, g, m_opr, m_opi, m_lat);
        end
      end else if (m_p == 1) begin
        m_p = 2;
      end else begin
        if (arc_done) begin
          m_resd[m_owner] = arc_data;
          nv[m_owner] = 1'b1;
          m_rr = ~m_owner;
          m_out = 0;
          $display("op %0d done req%0d angle=%0h", n_ops, m_owner, arc_data);
        end else if (m_p - 2 == TO - 1) begin
          m_err = 1;
          m_rr = ~m_owner;
          m_out = 0;
          $display("op %0d timeout req%0d", n_ops, m_owner);
        end else begin
          m_p++;
        end
      end
      m_resv = nv;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/qarctan_arbiter.md
QARCTAN_ARBITER -- requirements
Module: qarctan_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 32, sets the width of operands and results.
REQ-002 Parameter TIMEOUT, default 64, is the maximum number of WAIT cycles before the engine is declared hung.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  bit i: requester i presents an operand pair.
REQ-006 req_ready  output  2  bit i: the arbiter accepts requester i's operands this cycle.
REQ-007 req_real  input  2*DATA_SIZE  slice [i*DATA_SIZE +: DATA_SIZE] is requester i's signed real part.
REQ-008 req_imag  input  2*DATA_SIZE  slice i is requester i's signed imaginary part.
REQ-009 res_valid  output  2  bit i: result slot i holds an unread angle.
REQ-010 res_ready  input  2  bit i: consumer i takes the result this cycle.
REQ-011 res_data  output  2*DATA_SIZE  slice i is the angle for requester i.
REQ-012 arc_start  output  1  one-cycle start pulse to the shared quadrature-arctan engine.
REQ-013 arc_real  output  DATA_SIZE  real operand to the engine.
REQ-014 arc_imag  output  DATA_SIZE  imaginary operand to the engine.
REQ-015 arc_data  input  DATA_SIZE  engine result, valid only while arc_done is high.
REQ-016 arc_done  input  1  engine completion strobe.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 timeout_err  output  1  sticky flag: the engine failed to complete.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE and WAIT; only one operation SHALL be outstanding at a time.
REQ-020 Requester i is eligible in IDLE only when req_valid[i]=1 and res_valid[i]=0.
REQ-021 The round-robin pointer rr SHALL select the eligible requester rr if both are eligible; otherwise it SHALL select the single eligible requester.
REQ-022 req_ready SHALL be combinational, one-hot for the selected requester in IDLE, and all-zero in every other state.
REQ-023 On an accept edge the arbiter SHALL register both operands and the owner index, then go IDLE->ISSUE.
REQ-024 ISSUE: arc_start=1 for exactly one cycle, then ISSUE->WAIT unconditionally.
REQ-025 arc_real and arc_imag SHALL output the registered operands, held stable from ISSUE until the arbiter returns to IDLE, because the engine re-reads them after start.
REQ-026 WAIT: on arc_done=1, arc_data SHALL be registered into res_data slot owner and res_valid[owner] set, rr SHALL become ~owner, and the FSM SHALL go to IDLE.
REQ-027 WAIT: a cycle counter SHALL clear on entry to WAIT and increment every WAIT cycle.
REQ-028 If the counter reaches TIMEOUT-1 without arc_done, timeout_err SHALL be set, no result SHALL be written, rr SHALL become ~owner, and the FSM SHALL go to IDLE.
REQ-029 If arc_done arrives on the timeout cycle, completion SHALL take priority and timeout_err SHALL stay unchanged.
REQ-030 res_valid[i] SHALL clear on the edge where res_valid[i]&res_ready[i]; res_data slot i SHALL hold its value until overwritten.
REQ-031 arc_done outside WAIT SHALL be ignored.
REQ-032 Overhead latency: accept at edge N -> arc_start high in cycle N+1; arc_done in cycle M -> res_valid high in cycle M+1.
REQ-033 Throughput: a new accept is possible in the first IDLE cycle after completion.

Reset
REQ-034 While reset=0 (asynchronous): state=IDLE, rr=0, counter=0, res_valid=0, res_data=0, operand registers=0, timeout_err=0, arc_start=0, busy=0, req_ready=0.
REQ-035 Reset asserted mid-operation SHALL abort that operation with no result delivered; timeout_err clears only on reset.

Verification
REQ-036 Single request: req0 real=0x400, imag=0x400, engine model done after 40 cycles returning 0x324 -> arc_start 1 cycle after accept, res_valid[0]=1 with res_data[0]=0x324 one cycle after done.
REQ-037 Contention: both requesters valid from reset -> grants alternate 0,1,0,1 over four operations, each result routed to the correct slot.
REQ-038 Backpressure: res_ready[0]=0 with res_valid[0]=1 and req0 still valid -> req0 never granted; req1 is served; req0 is served after res_ready[0] pulses.
REQ-039 Hang: engine never asserts done -> timeout_err=1 after TIMEOUT WAIT cycles, FSM back in IDLE, res_valid unchanged, next request served.
REQ-040 Operand hold: change req_real/req_imag after accept -> arc_real/arc_imag stay at the accepted values until done.
REQ-041 Reset in WAIT -> all outputs at reset values within the same cycle; a done after release produces no result.
